neurosync_controller_uc: RTL
============================

// Module: neurosync_controller_uc
// PURPOSE
//  Game control unit (FSM) directly upstream of the neurosync dual datapath. Sequences one game:
//  start -> mode select -> 8 questions -> win/lose. Per question it drives the datapath control strobes
//  (zera, zera_prep_jogo, registra_modo, set_pos, conta_pergunta, jogando, medir) and scores results
//  returned by the button analyser (pronto_play/acertou_play) or range meter (acertou_faixa), by opcode.
// PARAMETERS
//  TIMEOUT_CICLOS  1_000_000_000  cycles allowed per question before counted as miss (20 s @50 MHz)
//  MEDIR_PERIODO   5_000_000      cycles between medir pulses in a distance question (100 ms)
//  HITS_FAIXA      3              consecutive in-range samples required for a distance hit
//  MAX_ERROS       3              misses that end the game as lost
// PORTS
//  clock               in   1  system clock
//  reset               in   1  synchronous, active-low reset (0 = reset)
//  jogar               in   1  start button, level; rising edge detected internally
//  confirma            in   1  confirm button, level; rising edge detected internally
//  opcode              in   2  current question type from datapath memory
//  is_ultima_pergunta  in   1  datapath question counter at last address
//  pronto_play         in   1  1-cycle pulse: button answer evaluated
//  acertou_play        in   1  button answer correct, valid with pronto_play
//  acertou_faixa       in   1  range meter: last measurement within limits (level)
//  zera                out  1  clears mode register and question counter
//  zera_prep_jogo      out  1  re-homes servo PWM
//  registra_modo       out  1  latches servo position as game mode
//  set_pos             out  1  loads question initial servo position
//  conta_pergunta      out  1  advances question address
//  jogando             out  1  question active (datapath shows question LEDs)
//  medir               out  1  1-cycle trigger for range meter
//  pontos              out  4  hits this game
//  erros               out  4  misses this game
//  ganhou / perdeu     out  1  game result flags, held until next start or reset
//  db_estado           out  4  state code
// BEHAVIOUR
//  - Reset (reset=0 at clock edge): state INICIAL, all outputs 0, pontos=erros=0, edge regs cleared.
//  - Edge detect: jogar_r/confirma_r registered; pulse = in & ~prev. Only edges are acted upon.
//  - All strobes are Moore outputs, exactly 1 cycle wide (one state visit).
//  - States (db_estado): INICIAL(0) PREPARA(1) ESCOLHE(2) REGISTRA(3) CARREGA(4) JOGA_BOTAO(5)
//    MEDE(6) AVALIA(7) PROXIMA(8) PERDEU(9) GANHOU(10) RESERVADO(11, never entered -> INICIAL).
//  - INICIAL: jogar edge -> PREPARA.  PREPARA: zera=zera_prep_jogo=1; pontos,erros,flags <= 0 -> ESCOLHE.
//  - ESCOLHE: wait confirma edge -> REGISTRA (registra_modo=1) -> CARREGA.
//  - CARREGA: set_pos=1; timer<=0; hit_run<=0; next by opcode: 00 -> JOGA_BOTAO, 01/10 -> MEDE,
//    11 -> AVALIA with hit=1 (reserved/free question).
//  - JOGA_BOTAO: jogando=1; timer++. pronto_play -> AVALIA, hit=acertou_play. Else timer==TIMEOUT_CICLOS-1
//    -> AVALIA, hit=0. pronto_play wins if same cycle as timeout.
//  - MEDE: jogando=1; timer++; period counter p: medir=1 when p==0; p wraps at MEDIR_PERIODO-1.
//    At p==MEDIR_PERIODO-1 sample acertou_faixa: 1 -> hit_run++, 0 -> hit_run<=0.
//    hit_run reaching HITS_FAIXA -> AVALIA, hit=1 (takes priority over same-cycle timeout); timeout -> hit=0.
//  - AVALIA: hit ? pontos++ : erros++ (saturate at 15). Next: erros(new)==MAX_ERROS -> PERDEU;
//    else is_ultima_pergunta -> GANHOU; else PROXIMA.
//  - PROXIMA: conta_pergunta=1 -> CARREGA (datapath address updates before CARREGA samples opcode).
//  - PERDEU: perdeu=1; GANHOU: ganhou=1; both hold, pontos/erros hold; jogar edge -> PREPARA.
//  - jogar/confirma edges ignored in all states not listed above; reset mid-game -> INICIAL next edge.
//  - Counters: timer 30 bits, p 23 bits, hit_run 2 bits (widths sized to defaults via $clog2).
// TESTING (bench uses TIMEOUT_CICLOS=200, MEDIR_PERIODO=10, HITS_FAIXA=3, MAX_ERROS=3)
//  1 reset=0 with jogar=1 -> state 0, all outputs 0; release, hold jogar high -> one PREPARA only.
//  2 jogar edge, confirma edge -> zera/zera_prep_jogo 1 cycle, registra_modo 1 cycle, then set_pos 1 cycle.
//  3 8x opcode 00, pronto_play with acertou_play=1 each -> 7 conta_pergunta pulses, pontos=8, ganhou=1.
//  4 opcode 01, acertou_faixa=1 constant -> medir every 10 cycles, hit after 3rd sample; 1,1,0,1,1,1 -> hit after 6.
//  5 three timeouts (no pronto_play for 200 cycles) -> erros=3, perdeu=1, no further conta_pergunta.
//  6 pronto_play coincident with timeout cycle, acertou_play=1 -> pontos++, erros unchanged.

Source files
------------

// File: rtl/neurosync_controller_uc.sv
// -----------------------------------------------------------------------------
// neurosync_controller_uc
// Game control unit for the neurosync dual datapath. Runs one game:
// start -> mode select -> up to 8 questions -> win/lose.
// Each question is a button question (opcode 00), a distance question
// (opcode 01/10) or a free question (opcode 11, always scored as a hit).
//
// Ports
//   clock              in   system clock
//   reset              in   synchronous active-low reset (0 = reset)
//   jogar              in   start button (level, rising edge used)
//   confirma           in   confirm button (level, rising edge used)
//   opcode[1:0]        in   question type of the current datapath address
//   is_ultima_pergunta in   datapath question counter at last address
//   pronto_play        in   1-cycle pulse: button answer evaluated
//   acertou_play       in   button answer correct (valid with pronto_play)
//   acertou_faixa      in   range meter: last measurement in range (level)
//   zera               out  clears mode register and question counter
//   zera_prep_jogo     out  re-homes servo PWM
//   registra_modo      out  latches servo position as game mode
//   set_pos            out  loads question initial servo position
//   conta_pergunta     out  advances question address
//   jogando            out  question active
//   medir              out  1-cycle trigger for range meter
//   pontos[3:0]        out  hits this game (saturating)
//   erros[3:0]         out  misses this game (saturating)
//   ganhou / perdeu    out  game result flags
//   db_estado[3:0]     out  current state code
// All outputs are registers; strobes are decoded from the next state so they
// line up exactly with the state visit that owns them.
// -----------------------------------------------------------------------------
module neurosync_controller_uc #(
  parameter int unsigned TIMEOUT_CICLOS = 1_000_000_000,
  parameter int unsigned MEDIR_PERIODO  = 5_000_000,
  parameter int unsigned HITS_FAIXA     = 3,
  parameter int unsigned MAX_ERROS      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       confirma,
  input  logic [1:0] opcode,
  input  logic       is_ultima_pergunta,
  input  logic       pronto_play,
  input  logic       acertou_play,
  input  logic       acertou_faixa,
  output logic       zera,
  output logic       zera_prep_jogo,
  output logic       registra_modo,
  output logic       set_pos,
  output logic       conta_pergunta,
  output logic       jogando,
  output logic       medir,
  output logic [3:0] pontos,
  output logic [3:0] erros,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int PW = (MEDIR_PERIODO > 1) ? $clog2(MEDIR_PERIODO) : 1;
  localparam int HW = $clog2(HITS_FAIXA + 1);

  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [PW-1:0] P_MAX     = PW'(MEDIR_PERIODO - 1);
  localparam logic [HW-1:0] HIT_LAST  = HW'(HITS_FAIXA - 1);
  localparam logic [3:0]    ERROS_LIM = 4'(MAX_ERROS);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    ESCOLHE    = 4'd2,
    REGISTRA   = 4'd3,
    CARREGA    = 4'd4,
    JOGA_BOTAO = 4'd5,
    MEDE       = 4'd6,
    AVALIA     = 4'd7,
    PROXIMA    = 4'd8,
    PERDEU     = 4'd9,
    GANHOU     = 4'd10,
    RESERVADO  = 4'd11
  } estado_t;

  // 4-bit increment that sticks at 15
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : (v + 4'd1);
  endfunction

  estado_t       state_q, state_d;
  logic          jogar_q, confirma_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] p_q, p_d;
  logic [HW-1:0] hit_run_q, hit_run_d;
  logic          hit_q, hit_d;
  logic [3:0]    pontos_q, pontos_d;
  logic [3:0]    erros_q, erros_d;
  logic          zera_q, zera_d;
  logic          zera_prep_q, zera_prep_d;
  logic          registra_q, registra_d;
  logic          set_pos_q, set_pos_d;
  logic          conta_q, conta_d;
  logic          jogando_q, jogando_d;
  logic          medir_q, medir_d;
  logic          ganhou_q, ganhou_d;
  logic          perdeu_q, perdeu_d;

  logic          jogar_pulse, confirma_pulse;
  logic          timeout_s;
  logic          sample_s;
  logic [3:0]    erros_new_s;

  assign jogar_pulse    = jogar & ~jogar_q;
  assign confirma_pulse = confirma & ~confirma_q;
  assign timeout_s      = (timer_q == TIMER_MAX);
  assign sample_s       = (p_q == P_MAX);
  assign erros_new_s    = hit_q ? erros_q : sat_inc4(erros_q);

  // Next-state and datapath-counter logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    p_d       = p_q;
    hit_run_d = hit_run_q;
    hit_d     = hit_q;
    pontos_d  = pontos_q;
    erros_d   = erros_q;
    case (state_q)
      INICIAL: begin
        if (jogar_pulse) state_d = PREPARA;
        else             state_d = INICIAL;
      end
      PREPARA: begin
        pontos_d = 4'd0;
        erros_d  = 4'd0;
        hit_d    = 1'b0;
        state_d  = ESCOLHE;
      end
      ESCOLHE: begin
        if (confirma_pulse) state_d = REGISTRA;
        else                state_d = ESCOLHE;
      end
      REGISTRA: state_d = CARREGA;
      CARREGA: begin
        timer_d   = '0;
        p_d       = '0;
        hit_run_d = '0;
        case (opcode)
          2'b00:   state_d = JOGA_BOTAO;
          2'b01:   state_d = MEDE;
          2'b10:   state_d = MEDE;
          default: begin
            hit_d   = 1'b1;
            state_d = AVALIA;
          end
        endcase
      end
      JOGA_BOTAO: begin
        timer_d = timer_q + TW'(1);
        // an answer arriving on the timeout cycle still counts
        if (pronto_play) begin
          hit_d   = acertou_play;
          state_d = AVALIA;
        end else if (timeout_s) begin
          hit_d   = 1'b0;
          state_d = AVALIA;
        end else begin
          state_d = JOGA_BOTAO;
        end
      end
      MEDE: begin
        timer_d = timer_q + TW'(1);
        if (sample_s) begin
          p_d = '0;
          if (acertou_faixa) hit_run_d = hit_run_q + HW'(1);
          else               hit_run_d = '0;
        end else begin
          p_d = p_q + PW'(1);
        end
        // completing the in-range run beats a same-cycle timeout
        if (sample_s && acertou_faixa && (hit_run_q == HIT_LAST)) begin
          hit_d   = 1'b1;
          state_d = AVALIA;
        end else if (timeout_s) begin
          hit_d   = 1'b0;
          state_d = AVALIA;
        end else begin
          state_d = MEDE;
        end
      end
      AVALIA: begin
        if (hit_q) pontos_d = sat_inc4(pontos_q);
        else       erros_d  = erros_new_s;
        if (erros_new_s == ERROS_LIM) state_d = PERDEU;
        else if (is_ultima_pergunta)  state_d = GANHOU;
        else                          state_d = PROXIMA;
      end
      PROXIMA: state_d = CARREGA;
      PERDEU: begin
        if (jogar_pulse) state_d = PREPARA;
        else             state_d = PERDEU;
      end
      GANHOU: begin
        if (jogar_pulse) state_d = PREPARA;
        else             state_d = GANHOU;
      end
      default: state_d = INICIAL;
    endcase
  end

  // Moore output decode of the state about to be entered
  always_comb begin
    zera_d      = 1'b0;
    zera_prep_d = 1'b0;
    registra_d  = 1'b0;
    set_pos_d   = 1'b0;
    conta_d     = 1'b0;
    jogando_d   = 1'b0;
    medir_d     = 1'b0;
    ganhou_d    = 1'b0;
    perdeu_d    = 1'b0;
    case (state_d)
      PREPARA: begin
        zera_d      = 1'b1;
        zera_prep_d = 1'b1;
      end
      REGISTRA:   registra_d = 1'b1;
      CARREGA:    set_pos_d  = 1'b1;
      JOGA_BOTAO: jogando_d  = 1'b1;
      MEDE: begin
        jogando_d = 1'b1;
        medir_d   = (p_d == '0);
      end
      PROXIMA:    conta_d  = 1'b1;
      PERDEU:     perdeu_d = 1'b1;
      GANHOU:     ganhou_d = 1'b1;
      default:    zera_d   = 1'b0;
    endcase
  end

  // State, counters, edge detectors and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= INICIAL;
      jogar_q     <= 1'b0;
      confirma_q  <= 1'b0;
      timer_q     <= '0;
      p_q         <= '0;
      hit_run_q   <= '0;
      hit_q       <= 1'b0;
      pontos_q    <= 4'd0;
      erros_q     <= 4'd0;
      zera_q      <= 1'b0;
      zera_prep_q <= 1'b0;
      registra_q  <= 1'b0;
      set_pos_q   <= 1'b0;
      conta_q     <= 1'b0;
      jogando_q   <= 1'b0;
      medir_q     <= 1'b0;
      ganhou_q    <= 1'b0;
      perdeu_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      jogar_q     <= jogar;
      confirma_q  <= confirma;
      timer_q     <= timer_d;
      p_q         <= p_d;
      hit_run_q   <= hit_run_d;
      hit_q       <= hit_d;
      pontos_q    <= pontos_d;
      erros_q     <= erros_d;
      zera_q      <= zera_d;
      zera_prep_q <= zera_prep_d;
      registra_q  <= registra_d;
      set_pos_q   <= set_pos_d;
      conta_q     <= conta_d;
      jogando_q   <= jogando_d;
      medir_q     <= medir_d;
      ganhou_q    <= ganhou_d;
      perdeu_q    <= perdeu_d;
    end
  end

  assign zera           = zera_q;
  assign zera_prep_jogo = zera_prep_q;
  assign registra_modo  = registra_q;
  assign set_pos        = set_pos_q;
  assign conta_pergunta = conta_q;
  assign jogando        = jogando_q;
  assign medir          = medir_q;
  assign pontos         = pontos_q;
  assign erros          = erros_q;
  assign ganhou         = ganhou_q;
  assign perdeu         = perdeu_q;
  assign db_estado      = state_q;

endmodule
